// File: rtl/filter_coef_pkg.sv
// Shared types and constants for the biquad coefficient loader and its bank.
// The default set is a passthrough (n1 = 1.0), so the filter is transparent until it is loaded.
package filter_coef_pkg;

  localparam int NUM_COEF = 5;
  localparam int COEF_W   = 32;
  localparam int ADDR_W   = 3;

  localparam int IDX_N1 = 0;
  localparam int IDX_N2 = 1;
  localparam int IDX_N3 = 2;
  localparam int IDX_D1 = 3;
  localparam int IDX_D2 = 4;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t DEFAULT_COEF [NUM_COEF] = '{
    32'sh0001_0000,
    32'sh0000_0000,
    32'sh0000_0000,
    32'sh0000_0000,
    32'sh0000_0000
  };

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_IDLE   = 2'd0;
  localparam loader_state_t ST_LOAD   = 2'd1;
  localparam loader_state_t ST_DRAIN  = 2'd2;
  localparam loader_state_t ST_COMMIT = 2'd3;

  // Out-of-range indices yield zero so banks wider than the default table stay defined.
  function automatic coef_t default_coef(input int idx);
    coef_t c;
    c = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (i == idx) c = DEFAULT_COEF[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/filter_coef_bank.sv
// Shadow/active coefficient storage: half-word writes into the shadow bank, an atomic
// whole-bank copy on commit, and a registered indexed read of the active bank.
module filter_coef_bank #(
  parameter int NUM_COEF = filter_coef_pkg::NUM_COEF,
  parameter int COEF_W   = filter_coef_pkg::COEF_W,
  parameter int ADDR_W   = filter_coef_pkg::ADDR_W,
  parameter int CNT_W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_idx,
  input  logic [15:0]              wr_data,
  input  logic                     commit,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [COEF_W-1:0] rd_data
);
  import filter_coef_pkg::*;

  logic [COEF_W-1:0] shadow_q [NUM_COEF];
  logic [COEF_W-1:0] shadow_d [NUM_COEF];
  logic [COEF_W-1:0] active_q [NUM_COEF];
  logic [COEF_W-1:0] active_d [NUM_COEF];
  logic [COEF_W-1:0] rd_data_q;
  logic [COEF_W-1:0] rd_data_d;
  logic [CNT_W-2:0]  wr_word;

  assign wr_word = wr_idx[CNT_W-1:1];

  // Even beats carry the integer half, odd beats the fraction; commit reads the shadow as
  // it stood before this edge so the copy is always a complete set.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    rd_data_d = '0;
    if (wr_en) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (wr_word == (CNT_W-1)'(i)) begin
          if (wr_idx[0]) shadow_d[i][15:0] = wr_data;
          else           shadow_d[i][COEF_W-1 -: 16] = wr_data;
        end
      end
    end
    if (commit) active_d = shadow_q;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data_d = active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= COEF_W'(default_coef(i));
      end
      rd_data_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/filter_coef_loader.sv
// Stream-side loader: frames 16-bit half-coefficient beats into a shadow set and commits
// it to the active bank only when exactly 2*NUM_COEF beats end with s_last.
module filter_coef_loader #(
  parameter int NUM_COEF = filter_coef_pkg::NUM_COEF,
  parameter int COEF_W   = filter_coef_pkg::COEF_W,
  parameter int ADDR_W   = filter_coef_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [15:0]              s_data,
  input  logic                     s_last,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [COEF_W-1:0] rd_data,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err
);
  import filter_coef_pkg::*;

  localparam int CNT_W = $clog2(2 * NUM_COEF);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(2 * NUM_COEF - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;
  logic             accept;
  logic             wr_en;

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_err_d = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_last) begin
            load_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = ST_COMMIT;
            end else begin
              load_err_d = 1'b1;
              state_d    = ST_DRAIN;
            end
          end else if (s_last) begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // Over-long set: swallow beats up to the source's own s_last without further errors.
      ST_DRAIN: begin
        if (accept && s_last) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with the state they describe.
  always_comb begin
    s_ready_d   = (state_d != ST_COMMIT);
    load_done_d = (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = (state_q != ST_IDLE);
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

  filter_coef_bank #(
    .NUM_COEF (NUM_COEF),
    .COEF_W   (COEF_W),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_data (s_data),
    .commit  (state_q == ST_COMMIT),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_filter_coef_loader.sv
// Directed bench for filter_coef_loader: framing, atomic commit, reset recovery and read timing.
module tb_filter_coef_loader;

  localparam logic [159:0] SET_A = {16'h0000, 16'h8000, 16'hFFFE, 16'h2EF4, 16'h0000,
                                    16'hE0F9, 16'h0001, 16'hE339, 16'hFFFF, 16'h1C98};
  localparam logic [159:0] SET_B = {16'h1234, 16'h5678, 16'hABCD, 16'h0001, 16'h7FFF,
                                    16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 16'h0042};

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_cnt = 0;
  logic        watch_en = 1'b0;
  logic [31:0] watch_val = '0;

  logic [31:0] exp_def [8];
  logic [31:0] exp_a [5];
  logic [31:0] exp_b [5];

  filter_coef_loader dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Pulse counters and the held-read watcher sample mid-cycle
  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt <= done_cnt + 1;
    if (load_err === 1'b1) err_cnt <= err_cnt + 1;
    if (watch_en && rd_data !== watch_val) bad_cnt <= bad_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    if (s_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL beat_accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
    end
    tick();
  endtask

  task automatic send_set(input logic [159:0] beats, input int n_beats, input int last_at,
                          input bit gaps);
    for (int k = 0; k < n_beats; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          tick();
        end
      end
      send_beat(beats[159-16*k -: 16], (k + 1) == last_at);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rd_addr = 3'd0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    reset   = 1'b1;
    tick();
    tests++;
    if ({s_ready, busy, load_done, load_err} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: ready/busy/done/err=%b, required 0000",
               {s_ready, busy, load_done, load_err});
    end
    tests++;
    if (rd_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_rd_data: got %h, required 00000000", rd_data);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: s_ready=%b busy=%b, required 1 0", s_ready, busy);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      tick();
      tests++;
      if (rd_data !== exp_def[a]) begin
        fails++;
        $display("[TB] FAIL default_read[%0d]: got %h, required %h", a, rd_data, exp_def[a]);
      end
    end
  endtask

  task automatic test_full_load();
    int d0;
    d0 = done_cnt;
    send_set(SET_A, 10, 10, 1'b0);
    tests++;
    if ({s_ready, load_done, load_err, busy} !== 4'b0101) begin
      fails++;
      $display("[TB] FAIL commit_cycle: ready/done/err/busy=%b, required 0101",
               {s_ready, load_done, load_err, busy});
    end
    tick();
    tests++;
    if ({s_ready, load_done, busy} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL after_commit: ready/done/busy=%b, required 100",
               {s_ready, load_done, busy});
    end
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("[TB] FAIL done_count_full: got %0d pulses, required 1", done_cnt - d0);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      tick();
      tests++;
      if (rd_data !== ((a < 5) ? exp_a[a] : 32'h0)) begin
        fails++;
        $display("[TB] FAIL set_a_read[%0d]: got %h, required %h", a, rd_data,
                 (a < 5) ? exp_a[a] : 32'h0);
      end
    end
  endtask

  task automatic test_early_last();
    int d0;
    d0 = done_cnt;
    send_set(SET_B, 4, 4, 1'b0);
    tests++;
    if ({load_err, load_done, busy, s_ready} !== 4'b1001) begin
      fails++;
      $display("[TB] FAIL early_last_flags: err/done/busy/ready=%b, required 1001",
               {load_err, load_done, busy, s_ready});
    end
    tick();
    tests++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL early_last_pulse_width: load_err=%b, required 0", load_err);
    end
    rd_addr = 3'd1;
    tick();
    tests++;
    if (rd_data !== exp_a[1]) begin
      fails++;
      $display("[TB] FAIL early_last_bank_kept: got %h, required %h", rd_data, exp_a[1]);
    end
    send_set(SET_B, 10, 10, 1'b0);
    tick();
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("[TB] FAIL done_count_after_err: got %0d pulses, required 1", done_cnt - d0);
    end
    for (int a = 0; a < 5; a++) begin
      rd_addr = 3'(a);
      tick();
      tests++;
      if (rd_data !== exp_b[a]) begin
        fails++;
        $display("[TB] FAIL set_b_read[%0d]: got %h, required %h", a, rd_data, exp_b[a]);
      end
    end
  endtask

  task automatic test_drain();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_set(SET_A, 10, 0, 1'b0);
    tests++;
    if ({load_err, busy, s_ready} !== 3'b111) begin
      fails++;
      $display("[TB] FAIL overlong_flags: err/busy/ready=%b, required 111", {load_err, busy, s_ready});
    end
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drain_exit: busy=%b, required 0", busy);
    end
    tick();
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      fails++;
      $display("[TB] FAIL drain_pulses: err=%0d done=%0d, required err=1 done=0",
               err_cnt - e0, done_cnt - d0);
    end
    rd_addr = 3'd0;
    tick();
    tests++;
    if (rd_data !== exp_b[0]) begin
      fails++;
      $display("[TB] FAIL drain_bank_kept: got %h, required %h", rd_data, exp_b[0]);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    send_set(SET_A, 6, 0, 1'b0);
    do_reset();
    tick();
    tests++;
    if (done_cnt - d0 !== 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    for (int a = 0; a < 5; a++) begin
      rd_addr = 3'(a);
      tick();
      tests++;
      if (rd_data !== exp_def[a]) begin
        fails++;
        $display("[TB] FAIL reset_mid_default[%0d]: got %h, required %h", a, rd_data, exp_def[a]);
      end
    end
    send_set(SET_B, 10, 10, 1'b0);
    tick();
    rd_addr = 3'd2;
    tick();
    tests++;
    if (rd_data !== exp_b[2]) begin
      fails++;
      $display("[TB] FAIL reset_mid_reload: got %h, required %h", rd_data, exp_b[2]);
    end
  endtask

  task automatic test_commit_hold();
    rd_addr = 3'd1;
    tick();
    tick();
    watch_val = exp_b[1];
    watch_en  = 1'b1;
    send_set(SET_A, 10, 10, 1'b1);
    tests++;
    if (load_done !== 1'b1 || rd_data !== exp_b[1]) begin
      fails++;
      $display("[TB] FAIL hold_commit_cycle: done=%b rd=%h, required 1 %h", load_done, rd_data, exp_b[1]);
    end
    tick();
    tests++;
    if (rd_data !== exp_b[1]) begin
      fails++;
      $display("[TB] FAIL hold_read_in_commit: got %h, required %h", rd_data, exp_b[1]);
    end
    watch_en = 1'b0;
    tick();
    tests++;
    if (rd_data !== exp_a[1]) begin
      fails++;
      $display("[TB] FAIL hold_read_after_commit: got %h, required %h", rd_data, exp_a[1]);
    end
    tests++;
    if (bad_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL hold_no_glitch: %0d cycles with other values, required 0", bad_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    send_set(SET_B, 10, 10, 1'b0);
    send_set(SET_A, 10, 10, 1'b0);
    tick();
    tick();
    tests++;
    if (done_cnt - d0 !== 2) begin
      fails++;
      $display("[TB] FAIL b2b_done_count: got %0d pulses, required 2", done_cnt - d0);
    end
    rd_addr = 3'd4;
    tick();
    tests++;
    if (rd_data !== exp_a[4]) begin
      fails++;
      $display("[TB] FAIL b2b_read: got %h, required %h", rd_data, exp_a[4]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_def = '{32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_a   = '{32'h0000_8000, 32'hFFFE_2EF4, 32'h0000_E0F9, 32'h0001_E339, 32'hFFFF_1C98};
    exp_b   = '{32'h1234_5678, 32'hABCD_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0042};
    test_reset();
    test_full_load();
    test_early_last();
    test_drain();
    test_reset_mid();
    test_commit_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_coef_loader.md
Name: filter_coef_loader

Overview:
- Writer-side companion to the biquad coefficient store.
- Accepts a runtime coefficient set (n1, n2, n3, d1, d2; signed Q16.16) over a 16-bit valid/ready stream and assembles it in a shadow bank.
- Once the full set has arrived with correct framing, commits it atomically to the active bank.
- The active bank is read by the IIR datapath through an indexed port with 1-cycle latency.

Parameters:
- NUM_COEF, 5, number of coefficients per set; index order n1, n2, n3, d1, d2 = 0..4.
- COEF_W, 32, coefficient width, signed Q16.16.
- ADDR_W, 3, read/write index width; must satisfy 2**ADDR_W >= NUM_COEF.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  16  half-coefficient; high half (integer part) first, then low half (fraction).
- s_last  in  1  marks the final beat of a set.
- rd_addr  in  ADDR_W  coefficient index for the datapath.
- rd_data  out  COEF_W  signed active coefficient, registered.
- busy  out  1  set in progress (state != IDLE).
- load_done  out  1  one-cycle pulse when a new set is committed.
- load_err  out  1  one-cycle pulse when a framing error is detected.

Behaviour:
- Reset (synchronous, active-high), values on the cycle after reset is sampled:
  - active bank = package defaults (n1=0x0001_0000, all others 0, i.e. passthrough).
  - shadow bank cleared; beat counter = 0; FSM = IDLE.
  - s_ready=0, load_done=0, load_err=0, busy=0, rd_data=0.
- Reset mid-load discards the partial set. The active bank reverts to the defaults, not the last committed set.
- Beat accepted when s_valid && s_ready. Beat counter cnt runs 0..2*NUM_COEF-1.
  - Even cnt: shadow[cnt/2][31:16] <= s_data.
  - Odd cnt: shadow[cnt/2][15:0] <= s_data.
- FSM:
  - IDLE: s_ready=1. First accepted beat -> LOAD, cnt=1.
    - If that beat has s_last=1, it is an early last: pulse load_err and stay in IDLE.
  - LOAD: s_ready=1. On each accepted beat:
    - Beat index 2*NUM_COEF-1 with s_last=1 -> COMMIT.
    - Beat index 2*NUM_COEF-1 with s_last=0 -> pulse load_err, go to DRAIN.
    - Any earlier beat with s_last=1 -> pulse load_err, go to IDLE; shadow contents are discarded.
  - DRAIN: s_ready=1. Beats are accepted and dropped until a beat with s_last=1 is accepted -> IDLE. No further error pulses.
  - COMMIT: s_ready=0 for exactly one cycle.
    - Active bank <= shadow, all NUM_COEF words in the same cycle.
    - load_done pulses this cycle; cnt=0; next state IDLE.
- The active bank is never partially updated. A read issued in the COMMIT cycle returns the old value; a read issued in the following cycle returns the new value.
- Read port: rd_data <= active[rd_addr] every cycle (1-cycle latency). rd_addr >= NUM_COEF returns 0.
- No back-pressure beyond the COMMIT cycle. s_valid while s_ready=0 is held by the source per normal valid/ready rules.
- load_done and load_err are never asserted in the same cycle.

Decomposition:
- Package filter_coef_pkg:
  - coef_t (logic signed [31:0]).
  - NUM_COEF; index constants IDX_N1..IDX_D2.
  - DEFAULT_COEF array.
  - loader state enum (IDLE, LOAD, DRAIN, COMMIT).
- Optional sub-module filter_coef_bank: dual bank (shadow/active) with half-word write, commit strobe and registered read. The FSM stays in filter_coef_loader.

Test Plan:
- Reset then read addrs 0..7 -> rd_data = 0x0001_0000, 0, 0, 0, 0, 0, 0, 0 (each 1 cycle after the address); busy=0, s_ready=1.
- Stream 10 beats 0x0000,0x8000, 0xFFFE,0x2EF4, 0x0000,0xE0F9, 0x0001,0xE339, 0xFFFF,0x1C98 with s_last on beat 10 ->
  - s_ready=0 for 1 cycle and load_done pulses.
  - Reads return 0x0000_8000, 0xFFFE_2EF4, 0x0000_E0F9, 0x0001_E339, 0xFFFF_1C98.
- s_last on beat 4 -> load_err pulse; active bank unchanged. The next full 10-beat set commits correctly.
- 10 beats without s_last, then 3 extra beats with s_last on the 3rd -> one load_err pulse, extra beats accepted; no commit; FSM returns to IDLE.
- Assert reset after beat 6 of a set -> defaults restored; no load_done. A new full set afterwards commits.
- Hold rd_addr=1 across commit -> old value in the COMMIT cycle, new value on the next cycle, no intermediate value; random s_valid gaps do not change the result.
